// File: rtl/clock_ui_pkg.sv
// Shared UI definitions for the digital clock: mode codes, arbiter states
// and the DIP-switch mode decode.
package clock_ui_pkg;

  localparam logic [1:0] MODE_WATCH     = 2'd0;
  localparam logic [1:0] MODE_SET       = 2'd1;
  localparam logic [1:0] MODE_ALARM     = 2'd2;
  localparam logic [1:0] MODE_STOPWATCH = 2'd3;

  localparam int unsigned RING_W = 8;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PEND,
    ST_CLR,
    ST_RING
  } state_t;

  // One-hot patterns select a mode; anything else falls back to the watch.
  function automatic logic [1:0] dip_decode(input logic [3:0] sw);
    logic [1:0] m;
    case (sw)
      4'b0001: m = MODE_SET;
      4'b0010: m = MODE_ALARM;
      4'b0100: m = MODE_STOPWATCH;
      default: m = MODE_WATCH;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ui_mode_arbiter_if.sv
// Bundle between the UI arbiter and its environment (switches, mode blocks, LCD).
interface ui_mode_arbiter_if;
  logic [3:0]  dip_sw;
  logic [3:0]  sw_in;
  logic        en_1hz;
  logic        alarm_hit;
  logic        frame_done;
  logic        lcd_clear_ack;
  logic [1:0]  mode_sel;
  logic [15:0] sw_to_mode;
  logic        lcd_clear_req;
  logic        alarm_on;

  modport slave (
    input  dip_sw, sw_in, en_1hz, alarm_hit, frame_done, lcd_clear_ack,
    output mode_sel, sw_to_mode, lcd_clear_req, alarm_on
  );

  modport master (
    output dip_sw, sw_in, en_1hz, alarm_hit, frame_done, lcd_clear_ack,
    input  mode_sel, sw_to_mode, lcd_clear_req, alarm_on
  );
endinterface

// File: rtl/dip_stabilizer.sv
// Decodes the DIP switches and only accepts a mode request once the decoded
// value has held for DIP_STABLE consecutive cycles.
module dip_stabilizer
  import clock_ui_pkg::*;
#(
  parameter int unsigned DIP_STABLE = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dip_sw,
  output logic [1:0] req_mode
);

  localparam int unsigned CW = (DIP_STABLE > 1) ? $clog2(DIP_STABLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIP_STABLE - 1);

  logic [1:0]    decoded;
  logic [1:0]    last_q;
  logic [CW-1:0] cnt_q;

  assign decoded = dip_decode(dip_sw);

  // The change edge itself is stable cycle 1, so acceptance lands DIP_STABLE
  // edges after the pattern changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q   <= MODE_WATCH;
      cnt_q    <= '0;
      req_mode <= MODE_WATCH;
    end else if (decoded != last_q) begin
      last_q <= decoded;
      cnt_q  <= '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_q <= cnt_q + CW'(1);
    end else begin
      req_mode <= last_q;
    end
  end

endmodule

// File: rtl/ui_mode_arbiter.sv
// Owns the active display mode, routes button edges to the active mode,
// synchronises mode changes with LCD frames and handles the alarm ring.
module ui_mode_arbiter
  import clock_ui_pkg::*;
#(
  parameter int unsigned DIP_STABLE = 1000,
  parameter int unsigned RING_SEC   = 30
) (
  input  logic               clk,
  input  logic               rst,
  ui_mode_arbiter_if.slave   bus
);

  logic [1:0]        req_mode;
  logic [3:0]        sw_prev;
  logic [3:0]        rise;

  state_t            state_q, state_n;
  logic [1:0]        mode_q, mode_n;
  logic [15:0]       route_q, route_n;
  logic              clr_q, clr_n;
  logic              ring_on_q, ring_on_n;
  logic [RING_W-1:0] ring_q, ring_n;

  dip_stabilizer #(.DIP_STABLE(DIP_STABLE)) u_dip_stabilizer (
    .clk      (clk),
    .rst      (rst),
    .dip_sw   (bus.dip_sw),
    .req_mode (req_mode)
  );

  // Previous levels reset high so a button held through reset never fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sw_prev <= '1;
    else     sw_prev <= bus.sw_in;
  end

  assign rise = bus.sw_in & ~sw_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      mode_q    <= MODE_WATCH;
      route_q   <= '0;
      clr_q     <= 1'b0;
      ring_on_q <= 1'b0;
      ring_q    <= '0;
    end else begin
      state_q   <= state_n;
      mode_q    <= mode_n;
      route_q   <= route_n;
      clr_q     <= clr_n;
      ring_on_q <= ring_on_n;
      ring_q    <= ring_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    mode_n    = mode_q;
    route_n   = '0;
    clr_n     = clr_q;
    ring_on_n = ring_on_q;
    ring_n    = ring_q;

    // Alarm preempts everything, including an in-flight clear handshake.
    if (bus.alarm_hit) begin
      state_n   = ST_RING;
      mode_n    = MODE_WATCH;
      clr_n     = 1'b0;
      ring_on_n = 1'b1;
      ring_n    = RING_W'(RING_SEC);
    end else begin
      case (state_q)
        ST_RUN: begin
          for (int unsigned m = 0; m < 4; m++) begin
            if (mode_q == 2'(m)) route_n[4*m +: 4] = rise;
          end
          if (req_mode != mode_q) state_n = ST_PEND;
        end
        ST_PEND: begin
          if (req_mode == mode_q) begin
            state_n = ST_RUN;
          end else if (bus.frame_done) begin
            mode_n  = req_mode;
            clr_n   = 1'b1;
            state_n = ST_CLR;
          end
        end
        ST_CLR: begin
          if (bus.lcd_clear_ack && clr_q) begin
            clr_n   = 1'b0;
            state_n = ST_RUN;
          end
        end
        ST_RING: begin
          if (bus.en_1hz && ring_q != '0) ring_n = ring_q - RING_W'(1);
          // The final tick, an already-empty counter or any press ends the ring;
          // the press itself is swallowed.
          if ((|rise) || ring_q == '0 || (bus.en_1hz && ring_q == RING_W'(1))) begin
            ring_n    = '0;
            ring_on_n = 1'b0;
            mode_n    = req_mode;
            clr_n     = 1'b1;
            state_n   = ST_CLR;
          end
        end
        default: state_n = ST_RUN;
      endcase
    end
  end

  assign bus.mode_sel      = mode_q;
  assign bus.sw_to_mode    = route_q;
  assign bus.lcd_clear_req = clr_q;
  assign bus.alarm_on      = ring_on_q;

endmodule
